// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_ctrl
// Description : Time-multiplexed scan controller for a 4-digit 7-segment
//               display. Each digit is driven for REFRESH_DIV cycles and
//               followed by GAP_CYC blank cycles to suppress ghosting. New
//               display contents are double-buffered: a load goes into a
//               pending buffer and is committed only at a frame boundary
//               (or at once while idle), so a frame never shows mixed data.
// Ports       : clk, rst (sync, active-high), en (scan enable),
//               data[15:0] / dp_in[3:0] / load (pending buffer write),
//               an[3:0] (active-low anodes), nib[3:0] (digit nibble),
//               dp (active-low decimal point), blank (segments off),
//               ack (commit pulse), frame_done (end of digit-3 slot).
// Options     : LEADING_ZERO_BLANK_EN - blank leading zero digits 3..1.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int GAP_CYC     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] data,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [3:0]  an,
    output logic [3:0]  nib,
    output logic        dp,
    output logic        blank,
    output logic        ack,
    output logic        frame_done
);

    localparam logic [1:0]  c_st_idle   = 2'd0;
    localparam logic [1:0]  c_st_show   = 2'd1;
    localparam logic [1:0]  c_st_gap    = 2'd2;
    localparam logic [19:0] c_show_last = 20'(REFRESH_DIV - 1);
    // Only meaningful when GAP_CYC > 0; the GAP state is unreachable otherwise.
    localparam logic [19:0] c_gap_last  = 20'(GAP_CYC - 1);

    logic [1:0]  r_state;
    logic [1:0]  r_digit;
    logic [19:0] r_cnt;
    logic [15:0] r_active;
    logic [3:0]  r_active_dp;
    logic [15:0] r_pending;
    logic [3:0]  r_pending_dp;
    logic        r_pending_vld;

    logic [1:0]  w_state_nxt;
    logic [1:0]  w_digit_nxt;
    logic [19:0] w_cnt_nxt;
    logic        w_frame_end;
    logic        w_commit_slot;
    logic [3:0]  w_lz;

    // ------------------------------------------------------------------------
    // Scan sequencer: state, digit index and dwell counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_digit <= 2'd0;
            r_cnt   <= 20'd0;
        end else begin
            r_state <= w_state_nxt;
            r_digit <= w_digit_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_digit_nxt = r_digit;
        w_cnt_nxt   = r_cnt;
        w_frame_end = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_digit_nxt = 2'd0;
                w_cnt_nxt   = 20'd0;
                if (en) begin
                    w_state_nxt = c_st_show;
                end
            end
            c_st_show: begin
                if (r_cnt == c_show_last) begin
                    w_cnt_nxt = 20'd0;
                    if (GAP_CYC > 0) begin
                        w_state_nxt = c_st_gap;
                    end else begin
                        // No gap: the last SHOW cycle of digit 3 closes the frame.
                        w_digit_nxt = r_digit + 2'd1;
                        w_frame_end = (r_digit == 2'd3);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 20'd1;
                end
            end
            c_st_gap: begin
                if (r_cnt == c_gap_last) begin
                    w_cnt_nxt   = 20'd0;
                    w_state_nxt = c_st_show;
                    w_digit_nxt = r_digit + 2'd1;
                    w_frame_end = (r_digit == 2'd3);
                end else begin
                    w_cnt_nxt = r_cnt + 20'd1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_digit_nxt = 2'd0;
                w_cnt_nxt   = 20'd0;
            end
        endcase
        // Disabling always wins and restarts the scan from digit 0 later.
        if (!en) begin
            w_state_nxt = c_st_idle;
            w_digit_nxt = 2'd0;
            w_cnt_nxt   = 20'd0;
        end
    end

    // ------------------------------------------------------------------------
    // Double buffer. Commits happen at a frame boundary, or in IDLE where no
    // frame is on screen. A load landing on a commit slot bypasses pending.
    // ------------------------------------------------------------------------
    assign w_commit_slot = w_frame_end || (r_state == c_st_idle);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active      <= 16'h0000;
            r_active_dp   <= 4'h0;
            r_pending     <= 16'h0000;
            r_pending_dp  <= 4'h0;
            r_pending_vld <= 1'b0;
        end else if (w_commit_slot && load) begin
            r_active      <= data;
            r_active_dp   <= dp_in;
            r_pending_vld <= 1'b0;
        end else if (w_commit_slot && r_pending_vld) begin
            r_active      <= r_pending;
            r_active_dp   <= r_pending_dp;
            r_pending_vld <= 1'b0;
        end else if (load) begin
            r_pending     <= data;
            r_pending_dp  <= dp_in;
            r_pending_vld <= 1'b1;
        end
    end

    assign ack        = !rst && w_commit_slot && (load || r_pending_vld);
    assign frame_done = !rst && w_frame_end;

    // ------------------------------------------------------------------------
    // Leading-zero mask: w_lz[i]=1 when digit i and every digit above it is 0.
    // ------------------------------------------------------------------------
`ifdef LEADING_ZERO_BLANK_EN
    assign w_lz[3] = (r_active[15:12] == 4'h0);
    assign w_lz[2] = w_lz[3] && (r_active[11:8] == 4'h0);
    assign w_lz[1] = w_lz[2] && (r_active[7:4] == 4'h0);
    assign w_lz[0] = 1'b0;
`else
    assign w_lz = 4'h0;
`endif

    // ------------------------------------------------------------------------
    // Output decode. nib follows the digit index, so it holds through GAP.
    // ------------------------------------------------------------------------
    always_comb begin
        an    = 4'hF;
        nib   = r_active[{r_digit, 2'b00} +: 4];
        dp    = 1'b1;
        blank = 1'b1;
        if (r_state == c_st_show) begin
            an    = ~(4'b0001 << r_digit);
            dp    = ~r_active_dp[r_digit];
            blank = w_lz[r_digit];
        end
        if (rst) begin
            an    = 4'hF;
            nib   = 4'h0;
            dp    = 1'b1;
            blank = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_ctrl
// Description : Self-checking bench for display_scan_ctrl. Two instances run
//               side by side (REFRESH_DIV=4/GAP_CYC=1 and REFRESH_DIV=3/
//               GAP_CYC=0) against a reference model that derives digit,
//               dwell and frame boundaries arithmetically from elapsed time.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_scan_ctrl;

    logic        clk;
    logic        r_rst;
    logic        r_en;
    logic [15:0] r_data;
    logic [3:0]  r_dp_in;
    logic        r_load;

    logic [3:0]  w_an0, w_nib0, w_an1, w_nib1;
    logic        w_dp0, w_blank0, w_ack0, w_fd0;
    logic        w_dp1, w_blank1, w_ack1, w_fd1;

    int checks = 0;
    int errors = 0;

    // Reference model state, one entry per instance
    int          c_r [2] = '{4, 3};
    int          c_g [2] = '{1, 0};
    bit          m_run [2];
    int          m_t   [2];
    logic [15:0] m_act [2];
    logic [3:0]  m_adp [2];
    logic [15:0] m_pnd [2];
    logic [3:0]  m_pdp [2];
    bit          m_pv  [2];

    display_scan_ctrl #(.REFRESH_DIV(4), .GAP_CYC(1)) u_dut0 (
        .clk(clk), .rst(r_rst), .en(r_en), .data(r_data), .dp_in(r_dp_in),
        .load(r_load), .an(w_an0), .nib(w_nib0), .dp(w_dp0), .blank(w_blank0),
        .ack(w_ack0), .frame_done(w_fd0)
    );

    display_scan_ctrl #(.REFRESH_DIV(3), .GAP_CYC(0)) u_dut1 (
        .clk(clk), .rst(r_rst), .en(r_en), .data(r_data), .dp_in(r_dp_in),
        .load(r_load), .an(w_an1), .nib(w_nib1), .dp(w_dp1), .blank(w_blank1),
        .ack(w_ack1), .frame_done(w_fd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int inst, input logic [3:0] obs,
                       input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d t=%0t observed=%h expected=%h", tag, inst, $time, obs, exp);
        end
    endtask

    function automatic logic lz_blank(input logic [15:0] a, input int d);
`ifdef LEADING_ZERO_BLANK_EN
        return (d > 0) && ((a >> (4 * d)) == 16'h0);
`else
        return 1'b0;
`endif
    endfunction

    // One clock cycle: apply inputs, compare both instances with the model,
    // then advance the model to the next cycle.
    task automatic step(input logic rs, input logic e, input logic l,
                        input logic [15:0] d, input logic [3:0] p);
        @(negedge clk);
        r_rst = rs; r_en = e; r_load = l; r_data = d; r_dp_in = p;
        #1;
        for (int i = 0; i < 2; i++) begin
            logic [3:0] e_an, e_nib, oh;
            logic       e_dp, e_blank, e_ack, e_fd, commit;
            int         slot, dg, pos;
            slot = c_r[i] + c_g[i];
            dg   = (m_t[i] / slot) % 4;
            pos  = m_t[i] % slot;
            e_an = 4'hF; e_dp = 1'b1; e_blank = 1'b1; e_fd = 1'b0;
            if (rs) begin
                e_nib = 4'h0; commit = 1'b0;
            end else if (!m_run[i]) begin
                e_nib  = m_act[i][3:0];
                commit = 1'b1;
            end else begin
                e_nib = m_act[i][4*dg +: 4];
                if (pos < c_r[i]) begin
                    oh      = 4'b0001 << dg;
                    e_an    = ~oh;
                    e_dp    = ~m_adp[i][dg];
                    e_blank = lz_blank(m_act[i], dg);
                end
                e_fd   = (m_t[i] % (4 * slot)) == (4 * slot - 1);
                commit = e_fd;
            end
            e_ack = commit && (l || m_pv[i]);

            chk("an",         i, (i == 0) ? w_an0 : w_an1, e_an);
            chk("nib",        i, (i == 0) ? w_nib0 : w_nib1, e_nib);
            chk("dp",         i, {3'b0, (i == 0) ? w_dp0 : w_dp1}, {3'b0, e_dp});
            chk("blank",      i, {3'b0, (i == 0) ? w_blank0 : w_blank1}, {3'b0, e_blank});
            chk("ack",        i, {3'b0, (i == 0) ? w_ack0 : w_ack1}, {3'b0, e_ack});
            chk("frame_done", i, {3'b0, (i == 0) ? w_fd0 : w_fd1}, {3'b0, e_fd});

            if (rs) begin
                m_run[i] = 1'b0; m_t[i] = 0; m_act[i] = 16'h0; m_adp[i] = 4'h0;
                m_pv[i] = 1'b0;
            end else begin
                if (commit && l) begin
                    m_act[i] = d; m_adp[i] = p; m_pv[i] = 1'b0;
                end else if (commit && m_pv[i]) begin
                    m_act[i] = m_pnd[i]; m_adp[i] = m_pdp[i]; m_pv[i] = 1'b0;
                end else if (l) begin
                    m_pnd[i] = d; m_pdp[i] = p; m_pv[i] = 1'b1;
                end
                if (!e) begin
                    m_run[i] = 1'b0; m_t[i] = 0;
                end else if (!m_run[i]) begin
                    m_run[i] = 1'b1; m_t[i] = 0;
                end else begin
                    m_t[i] = m_t[i] + 1;
                end
            end
        end
    endtask

    initial begin
        r_rst = 1'b1; r_en = 1'b0; r_load = 1'b0; r_data = 16'h0; r_dp_in = 4'h0;
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 1'b0; m_t[i] = 0; m_act[i] = 16'h0; m_adp[i] = 4'h0;
            m_pnd[i] = 16'h0; m_pdp[i] = 4'h0; m_pv[i] = 1'b0;
        end

        // Reset, with a load that must be discarded
        step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b0, 1'b1, 16'hBEEF, 4'hF);
        repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);

        // Free-running scan over two frames
        repeat (45) step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);

        // Mid-frame load held until frame end
        step(1'b0, 1'b1, 1'b1, 16'h1234, 4'b0101);
        repeat (30) step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);

        // Two loads in one frame: newest wins, single ack
        step(1'b0, 1'b1, 1'b1, 16'hAAAA, 4'hF);
        repeat (3) step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        step(1'b0, 1'b1, 1'b1, 16'h5555, 4'h2);
        repeat (30) step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);

        // Load exactly on the frame-end cycle of instance 0
        for (int k = 0; k < 40 && !(m_run[0] && (m_t[0] % 20) == 19); k++)
            step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        step(1'b0, 1'b1, 1'b1, 16'h00C0, 4'h1);
        repeat (25) step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);

        // Disable during digit-2 SHOW, then restart from digit 0
        for (int k = 0; k < 40 && !(m_run[0] && (m_t[0] % 20) == 11); k++)
            step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
        step(1'b0, 1'b0, 1'b1, 16'h9876, 4'h8);
        repeat (2) step(1'b0, 1'b0, 1'b0, 16'h0, 4'h0);
        repeat (25) step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);

        // Reset in the middle of a SHOW dwell
        step(1'b0, 1'b1, 1'b1, 16'h4321, 4'h3);
        repeat (6) step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 16'h0, 4'h0);
        repeat (25) step(1'b0, 1'b1, 1'b0, 16'h0, 4'h0);

        // Randomized traffic
        repeat (800) begin
            logic rs, e, l;
            rs = ($urandom_range(0, 79) == 0);
            e  = ($urandom_range(0, 15) != 0);
            l  = ($urandom_range(0, 5) == 0);
            step(rs, e, l, 16'($urandom), 4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clock cycles each digit is driven (SHOW dwell); legal range 1..2^20-1.
REQ-002 Parameter GAP_CYC, default 16, blank cycles between digits (anti-ghosting); 0 = no gap; legal range 0..255.
REQ-003 clk  input  1  system clock; all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  1 = scan; 0 = return to IDLE, display blanked.
REQ-006 data  input  16  four hex nibbles; data[3:0] = digit 0 (rightmost).
REQ-007 dp_in  input  4  decimal point request per digit, bit i = digit i.
REQ-008 load  input  1  one-cycle strobe capturing data/dp_in into pending buffer.
REQ-009 an  output  4  anode enables, active-low, one-hot-low or all-high.
REQ-010 nib  output  4  nibble of the digit currently driven, feeds 7-seg cathode decoder.
REQ-011 dp  output  1  decimal point, active-low, for current digit.
REQ-012 blank  output  1  1 = cathode decoder must drive all segments off.
REQ-013 ack  output  1  one-cycle pulse when pending buffer is committed to active buffer.
REQ-014 frame_done  output  1  one-cycle pulse at end of digit-3 dwell (plus its gap).

Function
REQ-015 FSM states IDLE, SHOW, GAP; encoding free; state, digit index (2 bits), dwell counter (20 bits) registered.
REQ-016 IDLE: an=4'b1111, blank=1, digit index=0; en=1 -> SHOW next cycle, counter cleared.
REQ-017 SHOW: an[digit]=0 others 1; nib=active[4*digit+3:4*digit]; dp=~active_dp[digit]; blank=0 (except REQ-025).
REQ-018 SHOW lasts exactly REFRESH_DIV cycles; then GAP if GAP_CYC>0, else SHOW of next digit directly.
REQ-019 GAP: an=4'b1111, blank=1, nib holds last value; lasts exactly GAP_CYC cycles, then SHOW of next digit.
REQ-020 Digit index increments 0->1->2->3->0 at each digit change; wraps modulo 4.
REQ-021 Frame end = last cycle of digit-3 dwell (last GAP cycle if GAP_CYC>0, else last SHOW cycle): frame_done=1 for that cycle.
REQ-022 load=1: data/dp_in captured into pending, pending_valid=1; later load overwrites pending (newest wins).
REQ-023 Commit at frame end when pending_valid=1: active<=pending, pending_valid<=0, ack=1 same cycle as frame_done; display never changes mid-frame.
REQ-024 load coincident with frame end: incoming data/dp_in committed directly to active, ack=1, pending_valid=0.
REQ-025 en=0 in any state: next cycle IDLE, an=4'b1111, blank=1; pending_valid retained; in IDLE with pending_valid=1, commit occurs immediately (ack pulse) since no frame is shown.
REQ-026 Exactly one an bit low at any time outside IDLE/GAP; never two.

Reset
REQ-027 rst=1 at clock edge: state=IDLE, digit=0, counter=0, active=16'h0000, active_dp=4'h0, pending_valid=0.
REQ-028 Outputs during/after reset: an=4'b1111, nib=4'h0, dp=1, blank=1, ack=0, frame_done=0.
REQ-029 rst takes priority over en and load; a load in a reset cycle is discarded.

Configuration
REQ-030 Macro LEADING_ZERO_BLANK_EN: defined -> in SHOW, digits 3..1 whose nibble is 0 and all higher digits are 0 drive blank=1 (anode still scanned, timing unchanged); digit 0 never blanked; dp still driven.
REQ-031 Undefined -> every digit displayed, including leading zeros; blank=1 only in IDLE/GAP/reset.

Verification (REFRESH_DIV=4, GAP_CYC=1 unless stated)
REQ-032 rst 2 cycles, en=1 -> an sequence 1110x4,1111x1,1101x4,1111x1,1011x4,1111x1,0111x4,1111x1; frame_done once per 20 cycles.
REQ-033 load data=16'h1234 mid-frame -> digits keep old value until frame end; ack with frame_done; next frame nib=4,3,2,1 on an[0..3].
REQ-034 load 16'hAAAA then 16'h5555 same frame -> single ack, next frame shows 5555.
REQ-035 load 16'h00C0 on the frame-end cycle -> ack that cycle, next frame shows 00C0; with LEADING_ZERO_BLANK_EN blank=1 on digits 3,2 only.
REQ-036 en=0 during digit-2 SHOW -> an=1111 next cycle; en=1 -> restarts at digit 0 with full REFRESH_DIV dwell.
REQ-037 GAP_CYC=0 -> no 1111 cycles between digits; frame = 16 cycles; rst mid-SHOW -> outputs per REQ-028 next cycle.
